midi_rx_parser: RTL and testbench
=================================

// Module: midi_rx_parser
// PURPOSE
//   Parametrised MIDI serial receiver and message assembler: oversamples the raw
//   MIDI line, frames 8N1 bytes, applies MIDI running-status parsing, and queues
//   complete messages in a DEPTH-entry FIFO with a valid/ready output handshake.
//   Feeds the voice/synth control logic with one 24-bit {status,data1,data2} word per message.
// PARAMETERS
//   CLKS_PER_BIT  1600  system clocks per MIDI bit (50 MHz / 31250 baud); must be >= 4
//   SYNC_STAGES   2     flops in midi_data input synchroniser; must be >= 2
//   DEPTH         8     message FIFO entries; power of 2, >= 2
// PORTS
//   clock          in   1   system clock, all logic on posedge
//   clr            in   1   asynchronous active-high reset
//   midi_data      in   1   raw MIDI line, idle high, asynchronous to clock
//   msg_bytes      out  24  FIFO head {status,data1,data2}; 24'h0 when FIFO empty
//   msg_valid      out  1   FIFO non-empty
//   msg_ready      in   1   consumer pops head on clock edge where msg_valid & msg_ready
//   busy_reading   out  1   high from start-bit detect to end of stop-bit sample
//   framing_error  out  1   1-cycle pulse: stop bit sampled low
//   overflow       out  1   1-cycle pulse: complete message dropped, FIFO full
//   fifo_count     out  $clog2(DEPTH)+1  entries currently held
// BEHAVIOUR
//   Reset: synchroniser flops = 1; FSM = IDLE; running status cleared; FIFO empty;
//     all outputs 0. clr mid-byte aborts the byte and any partial message.
//   Bit FSM: IDLE -> START on synchronised line == 0; START counts CLKS_PER_BIT/2
//     clocks, samples: 0 -> DATA, 1 -> IDLE (glitch, nothing reported).
//     DATA samples every CLKS_PER_BIT clocks, 8 bits LSB first -> STOP.
//     STOP samples after CLKS_PER_BIT: 1 -> byte strobe, IDLE; 0 -> framing_error
//     pulse, byte discarded, WAIT_HIGH until line == 1, then IDLE.
//   busy_reading: 1 in START/DATA/STOP/WAIT_HIGH, 0 in IDLE.
//   Parser (acts on byte strobe, cycle T):
//     0x80-0xBF, 0xE0-0xEF: running status = byte, need 2 data bytes, index reset.
//     0xC0-0xDF: running status = byte, need 1 data byte.
//     0xF0-0xF7: running status cleared; following data bytes ignored.
//     0xF8-0xFF (real-time): pushed immediately as {byte,8'h00,8'h00}; running
//       status and partial message untouched.
//     data byte, no running status: discarded.
//     data byte completing message: push {status,d1,d2} (d2 = 8'h00 for 1-byte
//       types); index returns to 0, running status retained.
//     framing error: partial data discarded, running status retained.
//   Latency: byte strobe at T -> FIFO write at T+1 -> msg_valid/msg_bytes at T+2
//     (if FIFO was empty).
//   FIFO: first-word-fall-through, order preserved. Push when full and no pop in
//     same cycle -> message dropped, overflow pulse at write cycle. Push and pop in
//     same cycle when full -> both succeed, count unchanged. Pop when empty ignored.
//     Pointers wrap modulo DEPTH.
// TESTING (bench: CLKS_PER_BIT=16, DEPTH=4, msg_ready=1 unless noted)
//   1. bytes 90 3C 64 -> one msg 24'h903C64, fifo_count 1->0 on pop.
//   2. 90 3C 64 3E 00 (running status) -> msgs 903C64 then 903E00.
//   3. 90 F8 3C 64, then C0 05 -> F80000, 903C64, C00500 in that order.
//   4. 90 3C, then byte with stop bit 0, then 40 7F -> framing_error one pulse,
//      busy held until line high; next msg 90407F.
//   5. msg_ready=0, five 2-byte msgs C0 01..C0 05 -> fifo_count=4, overflow one
//      pulse on 5th; drain yields C00100..C00400.
//   6. 8-clock low glitch -> no busy after START, no msg; clr asserted mid-DATA ->
//      all outputs 0 immediately, next clean 90 3C 64 -> 903C64.

Source files
------------

// File: rtl/midi_rx_parser.sv
// midi_rx_parser: MIDI 8N1 receiver with running-status message assembly and
// a first-word-fall-through message FIFO.
//   clock, clr       system clock (posedge) and asynchronous active-high reset
//   midi_data        raw MIDI line, idle high, asynchronous to clock
//   msg_bytes        FIFO head {status,data1,data2}, zero when the FIFO is empty
//   msg_valid        FIFO non-empty
//   msg_ready        consumer accepts the head when msg_valid is also high
//   busy_reading     a byte frame is in progress (start detect to stop sample)
//   framing_error    one-cycle pulse when the stop bit is sampled low
//   overflow         one-cycle pulse when a complete message was dropped
//   fifo_count       number of messages held
module midi_rx_parser #(
  parameter int unsigned CLKS_PER_BIT = 1600,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEPTH        = 8
) (
  input  logic                     clock,
  input  logic                     clr,
  input  logic                     midi_data,
  output logic [23:0]              msg_bytes,
  output logic                     msg_valid,
  input  logic                     msg_ready,
  output logic                     busy_reading,
  output logic                     framing_error,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FCNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH
  } state_t;

  // Input synchroniser; resets to the idle-high line level.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx;

  always_ff @(posedge clock or posedge clr) begin
    if (clr) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], midi_data};
  end

  assign rx = sync_q[SYNC_STAGES-1];

  // Bit-level framing FSM.
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             busy_d, fe_d, strobe_d, strobe_q;

  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      busy_reading  <= 1'b0;
      framing_error <= 1'b0;
      strobe_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      busy_reading  <= busy_d;
      framing_error <= fe_d;
      strobe_q      <= strobe_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    fe_d     = 1'b0;
    strobe_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx) state_d = S_START;
      end
      S_START: begin
        // Mid-start-bit sample; a high line here is treated as a glitch.
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          shift_d = {rx, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d = '0;
          if (rx) begin
            strobe_d = 1'b1;
            state_d  = S_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        cnt_d = '0;
        if (rx) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Running-status message assembler; shift_q holds the byte while strobe_q is high.
  logic [7:0]  rs_q, d1_q;
  logic        rs_valid_q, one_q, idx_q, push_q;
  logic [23:0] push_data_q;
  logic        is_rt, is_sys, is_one;

  assign is_rt  = (shift_q[7:3] == 5'b11111);
  assign is_sys = (shift_q[7:4] == 4'hF) && !is_rt;
  assign is_one = (shift_q[7:5] == 3'b110);

  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      rs_q        <= '0;
      d1_q        <= '0;
      rs_valid_q  <= 1'b0;
      one_q       <= 1'b0;
      idx_q       <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      push_q <= 1'b0;
      if (strobe_q) begin
        if (is_rt) begin
          push_q      <= 1'b1;
          push_data_q <= {shift_q, 16'h0000};
        end else if (is_sys) begin
          rs_valid_q <= 1'b0;
          idx_q      <= 1'b0;
        end else if (shift_q[7]) begin
          rs_q       <= shift_q;
          rs_valid_q <= 1'b1;
          one_q      <= is_one;
          idx_q      <= 1'b0;
        end else if (rs_valid_q) begin
          if (one_q) begin
            push_q      <= 1'b1;
            push_data_q <= {rs_q, shift_q, 8'h00};
          end else if (!idx_q) begin
            d1_q  <= shift_q;
            idx_q <= 1'b1;
          end else begin
            push_q      <= 1'b1;
            push_data_q <= {rs_q, d1_q, shift_q};
            idx_q       <= 1'b0;
          end
        end
      end else if (framing_error) begin
        idx_q <= 1'b0;
      end
    end
  end

  // Message FIFO; a push into a full FIFO still succeeds when the head pops that cycle.
  logic [23:0]       mem [DEPTH];
  logic [PTR_W-1:0]  wr_q, rd_q;
  logic              full, pop, wr_en;

  assign full  = (fifo_count == FCNT_W'(DEPTH));
  assign pop   = msg_ready && msg_valid;
  assign wr_en = push_q && (!full || pop);

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_q] <= push_data_q;
  end

  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      wr_q       <= '0;
      rd_q       <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      overflow <= push_q && full && !pop;
      if (wr_en) wr_q <= wr_q + PTR_W'(1);
      if (pop)   rd_q <= rd_q + PTR_W'(1);
      if (wr_en && !pop)      fifo_count <= fifo_count + FCNT_W'(1);
      else if (pop && !wr_en) fifo_count <= fifo_count - FCNT_W'(1);
    end
  end

  assign msg_valid = (fifo_count != '0);
  assign msg_bytes = msg_valid ? mem[rd_q] : 24'h0;

endmodule

// File: tb/tb_midi_rx_parser.sv
// Self-checking bench for midi_rx_parser: directed MIDI scenarios plus random
// byte streams, checked against a byte-level message model.
module tb_midi_rx_parser;
  localparam int unsigned CPB   = 16;
  localparam int unsigned DEPTH = 4;

  logic        clock = 1'b0;
  logic        clr = 1'b1;
  logic        midi_data = 1'b1;
  logic        msg_ready = 1'b1;
  logic [23:0] msg_bytes;
  logic        msg_valid, busy_reading, framing_error, overflow;
  logic [2:0]  fifo_count;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  midi_rx_parser #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2), .DEPTH(DEPTH)) dut (
    .clock(clock), .clr(clr), .midi_data(midi_data),
    .msg_bytes(msg_bytes), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .busy_reading(busy_reading), .framing_error(framing_error),
    .overflow(overflow), .fifo_count(fifo_count)
  );

  // Model state: expected message queue and running status.
  logic [23:0] exp_q[$];
  logic [23:0] dut_log[$];
  logic [7:0]  m_rs = 8'h00;
  logic [7:0]  m_d1 = 8'h00;
  int          m_idx = 0;
  int          exp_ovf = 0, exp_fe = 0, ovf_seen = 0, fe_seen = 0;
  bit          busy_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_push(input logic [23:0] m);
    if (!msg_ready && exp_q.size() >= DEPTH) exp_ovf++;
    else exp_q.push_back(m);
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (b >= 8'hF8) model_push({b, 16'h0000});
    else if (b >= 8'hF0) begin m_rs = 8'h00; m_idx = 0; end
    else if (b >= 8'h80) begin m_rs = b; m_idx = 0; end
    else if (m_rs != 8'h00) begin
      if (m_rs >= 8'hC0 && m_rs <= 8'hDF) model_push({m_rs, b, 8'h00});
      else if (m_idx == 0) begin m_d1 = b; m_idx = 1; end
      else begin model_push({m_rs, m_d1, b}); m_idx = 0; end
    end
  endfunction

  // Per-cycle output checks and pop scoreboard.
  always @(negedge clock) begin
    if (!clr) begin
      if (overflow) ovf_seen++;
      if (framing_error) fe_seen++;
      if (busy_reading) busy_seen = 1;
      check("valid_vs_count", 32'(msg_valid), 32'(fifo_count != 3'd0));
      if (!msg_valid) check("empty_bytes_zero", msg_bytes, 0);
      else if (msg_ready) begin
        dut_log.push_back(msg_bytes);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_msg: got %h expected none", msg_bytes);
        end else check("msg", msg_bytes, exp_q.pop_front());
      end
    end
  end

  task automatic drive(input logic v, input int n);
    midi_data = v;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad);
    if (bad) begin m_idx = 0; exp_fe++; end
    else model_byte(b);
    drive(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(b[i], CPB);
    drive(!bad, CPB);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || msg_valid) && n < 500) begin
      @(posedge clock); #1;
      n++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic check_log(input string name, input int n, input logic [3:0][23:0] e);
    check({name, "_count"}, dut_log.size(), n);
    for (int i = 0; i < n; i++)
      if (i < dut_log.size()) check({name, "_msg"}, dut_log[i], e[i]);
    dut_log.delete();
  endtask

  initial begin
    int fe0, ovf0;
    logic [7:0] b;
    repeat (3) @(posedge clock);
    #1;
    check("rst_valid", msg_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_bytes", msg_bytes, 0);
    check("rst_busy", busy_reading, 0);
    check("rst_fe", framing_error, 0);
    check("rst_ovf", overflow, 0);
    clr = 1'b0;
    drive(1'b1, 5);

    // 1: single note-on held, then popped
    msg_ready = 1'b0;
    send_byte(8'h90, 0); send_byte(8'h3C, 0); send_byte(8'h64, 0);
    drive(1'b1, 4);
    check("t1_count", fifo_count, 1);
    check("t1_valid", msg_valid, 1);
    check("t1_bytes", msg_bytes, 24'h903C64);
    msg_ready = 1'b1;
    @(posedge clock); #1;
    check("t1_count_after_pop", fifo_count, 0);
    wait_drain("t1");
    check_log("t1", 1, {24'h0, 24'h0, 24'h0, 24'h903C64});

    // 2: running status
    send_byte(8'h90, 0); send_byte(8'h3C, 0); send_byte(8'h64, 0);
    send_byte(8'h3E, 0); send_byte(8'h00, 0);
    wait_drain("t2");
    check_log("t2", 2, {24'h0, 24'h0, 24'h903E00, 24'h903C64});

    // 3: real-time byte inside a message, then 1-data-byte type
    send_byte(8'h90, 0); send_byte(8'hF8, 0); send_byte(8'h3C, 0); send_byte(8'h64, 0);
    send_byte(8'hC0, 0); send_byte(8'h05, 0);
    wait_drain("t3");
    check_log("t3", 3, {24'h0, 24'hC00500, 24'h903C64, 24'hF80000});

    // 4: framing error discards partial, keeps running status
    fe0 = fe_seen;
    send_byte(8'h90, 0); send_byte(8'h3C, 0);
    send_byte(8'h12, 1);
    drive(1'b0, 20);
    check("t4_busy_held", busy_reading, 1);
    drive(1'b1, 6);
    check("t4_busy_released", busy_reading, 0);
    check("t4_fe_pulses", fe_seen - fe0, 1);
    send_byte(8'h40, 0); send_byte(8'h7F, 0);
    wait_drain("t4");
    check_log("t4", 1, {24'h0, 24'h0, 24'h0, 24'h90407F});

    // 5: overflow with consumer stalled
    ovf0 = ovf_seen;
    msg_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send_byte(8'hC0, 0);
      send_byte(8'(i), 0);
    end
    drive(1'b1, 4);
    check("t5_count_full", fifo_count, 4);
    check("t5_ovf_pulses", ovf_seen - ovf0, 1);
    msg_ready = 1'b1;
    wait_drain("t5");
    check_log("t5", 4, {24'hC00400, 24'hC00300, 24'hC00200, 24'hC00100});

    // 6: start-bit glitch, then reset mid-byte
    fe0 = fe_seen;
    busy_seen = 0;
    drive(1'b0, 8);
    drive(1'b1, 30);
    check("t6_glitch_start_seen", busy_seen, 1);
    check("t6_glitch_busy", busy_reading, 0);
    check("t6_glitch_valid", msg_valid, 0);
    check("t6_glitch_fe", fe_seen - fe0, 0);
    msg_ready = 1'b0;
    send_byte(8'hC0, 0); send_byte(8'h01, 0);
    drive(1'b1, 4);
    check("t6_pre_clr_valid", msg_valid, 1);
    drive(1'b0, 3 * CPB);
    clr = 1'b1;
    #1;
    check("t6_clr_valid", msg_valid, 0);
    check("t6_clr_count", fifo_count, 0);
    check("t6_clr_bytes", msg_bytes, 0);
    check("t6_clr_busy", busy_reading, 0);
    check("t6_clr_fe", framing_error, 0);
    check("t6_clr_ovf", overflow, 0);
    exp_q.delete();
    dut_log.delete();
    m_rs = 8'h00;
    m_idx = 0;
    midi_data = 1'b1;
    msg_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    clr = 1'b0;
    drive(1'b1, 4);
    send_byte(8'h90, 0); send_byte(8'h3C, 0); send_byte(8'h64, 0);
    wait_drain("t6");
    check_log("t6", 1, {24'h0, 24'h0, 24'h0, 24'h903C64});

    // Random byte stream
    for (int n = 0; n < 60; n++) begin
      int k;
      k = int'($urandom_range(0, 9));
      if (k <= 2) b = {1'b1, 3'($urandom), 4'($urandom)};
      else if (k <= 7) b = {1'b0, 7'($urandom)};
      else if (k == 8) b = {5'b11111, 3'($urandom)};
      else b = 8'($urandom);
      if (k == 9) begin
        send_byte(b, 1);
        drive(1'b1, 2 * CPB);
      end else begin
        send_byte(b, 0);
        drive(1'b1, int'($urandom_range(0, 5)));
      end
    end
    wait_drain("rand");
    check("final_fe", fe_seen, exp_fe);
    check("final_ovf", ovf_seen, exp_ovf);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
